// File: rtl/huffman_symbol_sequencer.sv
// JPEG entropy symbol sequencer: turns one zigzag-ordered quantised block into
// DC / AC / ZRL / EOB symbols, keeping one DC predictor per colour component.
module huffman_symbol_sequencer #(
  parameter int COEF_W = 11,
  parameter int NCOEF  = 64,
  parameter int NCOMP  = 3,
  parameter int CID_W  = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [NCOEF*COEF_W-1:0] blk_coef,
  input  logic [CID_W-1:0]        blk_comp,
  input  logic                    restart,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic [1:0]              sym_type,
  output logic [3:0]              sym_run,
  output logic [3:0]              sym_size,
  output logic [14:0]             sym_bits,
  output logic [CID_W-1:0]        sym_comp,
  output logic                    sym_last,
  output logic                    busy,
  output logic [2:0]              dbg_state
);
  localparam int KW = $clog2(NCOEF);
  localparam int RW = (KW < 5) ? 5 : KW;

  typedef enum logic [2:0] {S_IDLE, S_DC, S_SCAN, S_ZRL, S_AC, S_EOB} state_t;

  state_t                     r_state;
  logic [KW-1:0]              r_k;
  logic [KW-1:0]              r_lastnz;
  logic [RW-1:0]              r_run;
  logic signed [COEF_W-1:0]   r_coef [NCOEF];
  logic signed [COEF_W-1:0]   r_pred [NCOMP];

  logic signed [COEF_W-1:0]   w_pred_sel;
  logic signed [COEF_W-1:0]   w_coef0;
  logic signed [COEF_W:0]     w_diff;
  logic [KW-1:0]              w_lastnz;
  logic signed [COEF_W-1:0]   w_cur;
  logic [18:0]                w_dc_enc;
  logic [18:0]                w_ac_enc;
  logic                       w_accept;

  // Returns {category, amplitude bits}; negative values carry the one's complement of |v|.
  function automatic logic [18:0] encode(input logic signed [15:0] v);
    logic [14:0] mag;
    logic [14:0] mask;
    logic [14:0] amp;
    logic [3:0]  sz;
    mag = 15'(v[15] ? -v : v);
    sz = 4'd0;
    for (int i = 0; i < 15; i++)
      if (mag[i]) sz = 4'(i + 1);
    mask = (15'd1 << sz) - 15'd1;
    amp = v[15] ? ((v[14:0] - 15'd1) & mask) : v[14:0];
    return {sz, amp};
  endfunction

  assign w_accept  = (r_state == S_IDLE) && blk_valid;
  assign dbg_state = r_state;

  // A restart coinciding with an accept makes the new block predict from zero.
  always_comb begin
    w_pred_sel = '0;
    if (!restart)
      for (int c = 0; c < NCOMP; c++)
        if (blk_comp == CID_W'(c)) w_pred_sel = r_pred[c];
    w_coef0 = blk_coef[COEF_W-1:0];
    w_diff = {w_coef0[COEF_W-1], w_coef0} - {w_pred_sel[COEF_W-1], w_pred_sel};
    w_lastnz = '0;
    for (int k = 1; k < NCOEF; k++)
      if (blk_coef[k*COEF_W +: COEF_W] != '0) w_lastnz = KW'(k);
    w_cur = r_coef[r_k];
    w_dc_enc = encode(16'(w_diff));
    w_ac_enc = encode(16'(w_cur));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCOMP; c++) r_pred[c] <= '0;
    end else begin
      for (int c = 0; c < NCOMP; c++) begin
        if (w_accept && blk_comp == CID_W'(c)) r_pred[c] <= w_coef0;
        else if (restart)                       r_pred[c] <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept)
      for (int i = 0; i < NCOEF; i++) r_coef[i] <= blk_coef[i*COEF_W +: COEF_W];
  end

  // Handshake: a symbol is transferred on an edge where sym_valid && sym_ready;
  // until then every sym_* output holds. A block is taken when blk_valid && blk_ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_lastnz  <= '0;
      r_run     <= '0;
      blk_ready <= 1'b1;
      busy      <= 1'b0;
      sym_valid <= 1'b0;
      sym_type  <= '0;
      sym_run   <= '0;
      sym_size  <= '0;
      sym_bits  <= '0;
      sym_comp  <= '0;
      sym_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (blk_valid) begin
            r_lastnz  <= w_lastnz;
            sym_valid <= 1'b1;
            sym_type  <= 2'd0;
            sym_run   <= 4'd0;
            sym_size  <= w_dc_enc[18:15];
            sym_bits  <= w_dc_enc[14:0];
            sym_comp  <= blk_comp;
            sym_last  <= 1'b0;
            busy      <= 1'b1;
            blk_ready <= 1'b0;
            r_state   <= S_DC;
          end
        end
        S_DC: begin
          if (sym_ready) begin
            if (r_lastnz == '0) begin
              sym_type <= 2'd3;
              sym_run  <= 4'd0;
              sym_size <= 4'd0;
              sym_bits <= '0;
              sym_last <= 1'b1;
              r_state  <= S_EOB;
            end else begin
              sym_valid <= 1'b0;
              r_k       <= KW'(1);
              r_run     <= '0;
              r_state   <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_cur == '0) begin
            r_run <= r_run + RW'(1);
            r_k   <= r_k + KW'(1);
          end else if (r_run >= RW'(16)) begin
            sym_valid <= 1'b1;
            sym_type  <= 2'd2;
            sym_run   <= 4'd15;
            sym_size  <= 4'd0;
            sym_bits  <= '0;
            sym_last  <= 1'b0;
            r_state   <= S_ZRL;
          end else begin
            sym_valid <= 1'b1;
            sym_type  <= 2'd1;
            sym_run   <= r_run[3:0];
            sym_size  <= w_ac_enc[18:15];
            sym_bits  <= w_ac_enc[14:0];
            sym_last  <= (r_k == KW'(NCOEF - 1));
            r_state   <= S_AC;
          end
        end
        S_ZRL: begin
          if (sym_ready) begin
            sym_valid <= 1'b0;
            r_run     <= r_run - RW'(16);
            r_state   <= S_SCAN;
          end
        end
        S_AC: begin
          if (sym_ready) begin
            if (r_k != r_lastnz) begin
              sym_valid <= 1'b0;
              r_k       <= r_k + KW'(1);
              r_run     <= '0;
              r_state   <= S_SCAN;
            end else if (r_lastnz != KW'(NCOEF - 1)) begin
              sym_type <= 2'd3;
              sym_run  <= 4'd0;
              sym_size <= 4'd0;
              sym_bits <= '0;
              sym_last <= 1'b1;
              r_state  <= S_EOB;
            end else begin
              sym_valid <= 1'b0;
              sym_type  <= '0;
              sym_run   <= '0;
              sym_size  <= '0;
              sym_bits  <= '0;
              sym_comp  <= '0;
              sym_last  <= 1'b0;
              busy      <= 1'b0;
              blk_ready <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end
        S_EOB: begin
          if (sym_ready) begin
            sym_valid <= 1'b0;
            sym_type  <= '0;
            sym_run   <= '0;
            sym_size  <= '0;
            sym_bits  <= '0;
            sym_comp  <= '0;
            sym_last  <= 1'b0;
            busy      <= 1'b0;
            blk_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_symbol_sequencer.sv
// Bench for huffman_symbol_sequencer: random blocks and back-pressure checked
// against a symbol-list model of JPEG run-length coding.
module tb_huffman_symbol_sequencer;
  localparam int COEF_W = 11;
  localparam int NCOEF  = 64;
  localparam int NCOMP  = 3;
  localparam int CID_W  = 2;
  localparam int SW     = 28;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    blk_valid;
  logic                    blk_ready;
  logic [NCOEF*COEF_W-1:0] blk_coef;
  logic [CID_W-1:0]        blk_comp;
  logic                    restart;
  logic                    sym_valid;
  logic                    sym_ready;
  logic [1:0]              sym_type;
  logic [3:0]              sym_run;
  logic [3:0]              sym_size;
  logic [14:0]             sym_bits;
  logic [CID_W-1:0]        sym_comp;
  logic                    sym_last;
  logic                    busy;
  logic [2:0]              dbg_state;

  huffman_symbol_sequencer #(
    .COEF_W(COEF_W), .NCOEF(NCOEF), .NCOMP(NCOMP), .CID_W(CID_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_coef(blk_coef), .blk_comp(blk_comp), .restart(restart),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_type(sym_type),
    .sym_run(sym_run), .sym_size(sym_size), .sym_bits(sym_bits),
    .sym_comp(sym_comp), .sym_last(sym_last), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int            tests = 0;
  int            fails = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] gen_q[$];
  logic [SW-1:0] ref_q[$];
  int            drv_coef[NCOEF];
  int            exp_pred[NCOMP];
  bit            exp_busy;
  int            ready_mode;
  int            stall_cnt;
  bit            prev_stall;
  logic [SW:0]   prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Symbol layout: {comp, type, run, size, bits, last}
  function automatic logic [SW-1:0] pack(input int comp, input int typ, input int run,
                                         input int size, input int bits, input bit last);
    return {2'(comp), 2'(typ), 4'(run), 4'(size), 15'(bits), last};
  endfunction

  function automatic int cat_of(input int v);
    int m = (v < 0) ? -v : v;
    int s = 0;
    while (m > 0) begin
      s++;
      m = m >> 1;
    end
    return s;
  endfunction

  function automatic int amp_of(input int v);
    int s = cat_of(v);
    if (v >= 0) return v;
    return ((1 << s) - 1) - (-v);
  endfunction

  function automatic void gen_syms(input int c[NCOEF], input int comp, input int pred);
    int diff = c[0] - pred;
    int last = 0;
    int run  = 0;
    gen_q.push_back(pack(comp, 0, 0, cat_of(diff), amp_of(diff), 1'b0));
    for (int k = 1; k < NCOEF; k++)
      if (c[k] != 0) last = k;
    for (int k = 1; k <= last; k++) begin
      if (c[k] == 0) run++;
      else begin
        while (run >= 16) begin
          gen_q.push_back(pack(comp, 2, 15, 0, 0, 1'b0));
          run -= 16;
        end
        gen_q.push_back(pack(comp, 1, run, cat_of(c[k]), amp_of(c[k]), k == NCOEF - 1));
        run = 0;
      end
    end
    if (last < NCOEF - 1) gen_q.push_back(pack(comp, 3, 0, 0, 0, 1'b1));
  endfunction

  task automatic check_gen(input string name);
    check({name, "_len"}, gen_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < gen_q.size(); i++) check(name, gen_q[i], ref_q[i]);
    gen_q.delete();
    ref_q.delete();
  endtask

  task automatic clr();
    foreach (drv_coef[i]) drv_coef[i] = 0;
  endtask

  task automatic send_block(input int comp, input bit with_rst);
    int n = 0;
    for (int k = 0; k < NCOEF; k++) blk_coef[k*COEF_W +: COEF_W] = COEF_W'(drv_coef[k]);
    blk_comp  = CID_W'(comp);
    blk_valid = 1'b1;
    while (!blk_ready && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    if (!blk_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: blk_ready 0 expected 1");
    end else restart = with_rst;
    @(posedge clock); #1;
    blk_valid = 1'b0;
    restart   = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clock); #1;
    restart = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !blk_ready) && n < 5000) begin
      @(posedge clock); #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || !blk_ready) begin
      fails++;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
    end
  endtask

  function automatic int rand_val();
    int m = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 1023));
    return ($urandom_range(0, 1) == 0) ? m : -m;
  endfunction

  // Compare process: samples on the falling edge, mid-cycle between DUT updates.
  always @(negedge clock) begin : mon
    logic [SW:0]   cur;
    logic [SW-1:0] e;
    int            ci;
    cur = {sym_valid, sym_comp, sym_type, sym_run, sym_size, sym_bits, sym_last};
    if (!reset_n) begin
      check("reset_sym", cur, '0);
      check("reset_hs", {busy, blk_ready}, 2'b01);
      exp_q.delete();
      foreach (exp_pred[i]) exp_pred[i] = 0;
      exp_busy   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("busy_ready", {busy, blk_ready}, {exp_busy, !exp_busy});
      if (!exp_busy) check("idle_valid", sym_valid, 0);
      if (prev_stall) check("hold", cur, prev_out);
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sym_extra: got %h expected none", cur[SW-1:0]);
        end else begin
          e = exp_q.pop_front();
          check("sym", cur[SW-1:0], e);
          if (e[0]) exp_busy = 1'b0;
        end
      end
      prev_stall = sym_valid && !sym_ready;
      prev_out   = cur;
      ci = int'(blk_comp);
      if (blk_valid && blk_ready) begin
        gen_syms(drv_coef, ci, restart ? 0 : exp_pred[ci]);
        foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
        gen_q.delete();
        exp_busy = 1'b1;
      end
      if (restart) foreach (exp_pred[i]) exp_pred[i] = 0;
      if (blk_valid && blk_ready) exp_pred[ci] = drv_coef[0];
    end
  end

  initial begin
    sym_ready = 1'b0;
    stall_cnt = 0;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0: sym_ready = 1'b1;
        1: sym_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (sym_valid && stall_cnt >= 5) begin
            sym_ready = 1'b1;
            stall_cnt = 0;
          end else begin
            sym_ready = 1'b0;
            if (sym_valid) stall_cnt++;
          end
        end
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dens;
    reset_n    = 1'b1;
    blk_valid  = 1'b0;
    blk_coef   = '0;
    blk_comp   = '0;
    restart    = 1'b0;
    ready_mode = 0;
    exp_busy   = 1'b0;
    prev_stall = 1'b0;
    prev_out   = '0;
    foreach (exp_pred[i]) exp_pred[i] = 0;

    // Hand-worked symbol lists pinning the model
    clr(); drv_coef[0] = 50;
    gen_syms(drv_coef, 0, 0);
    ref_q.push_back(pack(0, 0, 0, 6, 50, 1'b0));
    ref_q.push_back(pack(0, 3, 0, 0, 0, 1'b1));
    check_gen("pin_dc50");
    clr(); drv_coef[0] = 47; drv_coef[1] = -3; drv_coef[5] = 1;
    gen_syms(drv_coef, 0, 50);
    ref_q.push_back(pack(0, 0, 0, 2, 0, 1'b0));
    ref_q.push_back(pack(0, 1, 0, 2, 0, 1'b0));
    ref_q.push_back(pack(0, 1, 3, 1, 1, 1'b0));
    ref_q.push_back(pack(0, 3, 0, 0, 0, 1'b1));
    check_gen("pin_ac");
    clr(); drv_coef[40] = 5;
    gen_syms(drv_coef, 1, 0);
    ref_q.push_back(pack(1, 0, 0, 0, 0, 1'b0));
    ref_q.push_back(pack(1, 2, 15, 0, 0, 1'b0));
    ref_q.push_back(pack(1, 2, 15, 0, 0, 1'b0));
    ref_q.push_back(pack(1, 1, 7, 3, 5, 1'b0));
    ref_q.push_back(pack(1, 3, 0, 0, 0, 1'b1));
    check_gen("pin_zrl");
    clr(); drv_coef[63] = -1;
    gen_syms(drv_coef, 2, 0);
    ref_q.push_back(pack(2, 0, 0, 0, 0, 1'b0));
    ref_q.push_back(pack(2, 2, 15, 0, 0, 1'b0));
    ref_q.push_back(pack(2, 2, 15, 0, 0, 1'b0));
    ref_q.push_back(pack(2, 2, 15, 0, 0, 1'b0));
    ref_q.push_back(pack(2, 1, 14, 1, 0, 1'b1));
    check_gen("pin_last63");
    clr(); drv_coef[0] = 1023;
    gen_syms(drv_coef, 0, -1024);
    ref_q.push_back(pack(0, 0, 0, 11, 2047, 1'b0));
    ref_q.push_back(pack(0, 3, 0, 0, 0, 1'b1));
    check_gen("pin_maxpos");
    clr(); drv_coef[0] = -1024;
    gen_syms(drv_coef, 0, 1023);
    ref_q.push_back(pack(0, 0, 0, 11, 0, 1'b0));
    ref_q.push_back(pack(0, 3, 0, 0, 0, 1'b1));
    check_gen("pin_maxneg");

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Directed blocks, ready always high
    clr(); drv_coef[0] = 50;                                        send_block(0, 1'b0);
    clr(); drv_coef[0] = 47; drv_coef[1] = -3; drv_coef[5] = 1;     send_block(0, 1'b0);
    clr(); drv_coef[40] = 5;                                        send_block(1, 1'b0);
    clr(); drv_coef[0] = 7; drv_coef[63] = -1;                      send_block(2, 1'b0);
    clr(); drv_coef[0] = 1023;                                      send_block(1, 1'b0);
    clr(); drv_coef[0] = -1024;                                     send_block(1, 1'b0);
    clr(); drv_coef[0] = 1023; drv_coef[63] = -1024;                send_block(1, 1'b0);
    wait_idle();

    // Same shapes under five-cycle stalls on every symbol
    ready_mode = 2;
    clr(); drv_coef[0] = 50;                                        send_block(0, 1'b0);
    clr(); drv_coef[0] = 47; drv_coef[1] = -3; drv_coef[5] = 1;     send_block(0, 1'b0);
    clr(); drv_coef[40] = 5;                                        send_block(1, 1'b0);
    clr(); drv_coef[63] = -1;                                       send_block(2, 1'b0);
    wait_idle();

    // Restart between blocks, then restart coincident with an accept
    ready_mode = 0;
    clr(); drv_coef[0] = 100; send_block(0, 1'b0);
    wait_idle();
    pulse_restart();
    clr(); drv_coef[0] = 100; send_block(0, 1'b0);
    clr(); drv_coef[0] = 30;  send_block(2, 1'b0);
    clr(); drv_coef[0] = -5;  drv_coef[2] = 4; send_block(1, 1'b1);
    clr(); drv_coef[0] = 30;  send_block(2, 1'b0);
    wait_idle();

    // Random blocks with random back-pressure and occasional restarts
    ready_mode = 1;
    for (int b = 0; b < 60; b++) begin
      clr();
      drv_coef[0] = int'($urandom_range(0, 2047)) - 1024;
      dens = int'($urandom_range(0, 4));
      for (int k = 1; k < NCOEF; k++)
        if (int'($urandom_range(0, 31)) < dens) drv_coef[k] = rand_val();
      if ($urandom_range(0, 5) == 0) drv_coef[NCOEF-1] = rand_val();
      send_block(int'($urandom_range(0, NCOMP - 1)), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) pulse_restart();
    end
    wait_idle();

    // Reset (with restart) in the middle of a stalled block
    ready_mode = 2;
    clr(); drv_coef[0] = 9; drv_coef[10] = 3;
    send_block(0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    restart = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    restart = 1'b0;
    reset_n = 1'b1;
    ready_mode = 0;
    clr(); drv_coef[0] = 9; drv_coef[10] = 3;
    send_block(0, 1'b0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
